// File: rtl/rf16_32bits_writer_pkg.sv
// Shared constants, FSM encoding and write payload type for the 16x32 register bank.
// Optional byte-strobe write support is enabled by defining RF_BYTE_STROBE_EN.
package rf16_32bits_writer_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ADDR_W   = 4;
    localparam int unsigned NUM_REGS = 16;
    localparam int unsigned BE_W     = DATA_W / 8;
    localparam int unsigned Q_W      = DATA_W * NUM_REGS;

    localparam logic [DATA_W-1:0] CLR_VAL = 32'h0000_0000;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [BE_W-1:0]   be;
    } wr_cmd_t;

    // Replace only the byte lanes selected by be
    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0] cur,
        input logic [DATA_W-1:0] wdata,
        input logic [BE_W-1:0]   be
    );
        logic [DATA_W-1:0] res;
        res = cur;
        for (int unsigned k = 0; k < BE_W; k++) begin
            if (be[k]) res[8*k +: 8] = wdata[8*k +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/rf16_32bits_writer_write_dec4to16.sv
// One-hot register-enable decoder for the write side of the register bank.
module write_dec4to16
    import rf16_32bits_writer_pkg::*;
(
    input  logic                en,
    input  logic [ADDR_W-1:0]   addr,
    output logic [NUM_REGS-1:0] sel_c
);

    always_comb begin
        sel_c = '0;
        if (en) sel_c[addr] = 1'b1;
    end

endmodule

// File: rtl/rf16_32bits_writer.sv
// Write side of the 16x32 register bank: write handshake, clear sweep FSM, flat q bus.
// Define RF_BYTE_STROBE_EN to add the wr_be byte-lane write enables.
module rf16_32bits_writer
    import rf16_32bits_writer_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
`ifdef RF_BYTE_STROBE_EN
    input  logic [BE_W-1:0]   wr_be,
`endif
    input  logic              clr_req,
    output logic              busy,
    output logic              wr_ack,
    output logic [Q_W-1:0]    q
);

    state_e              state, state_nxt;
    logic [ADDR_W-1:0]   clr_cnt, clr_cnt_nxt;
    logic                wr_accept_c, clr_step_c;
    logic                ready_nxt, busy_nxt, ack_nxt;
    logic [BE_W-1:0]     be_in_c;
    wr_cmd_t             cmd_c;
    logic [NUM_REGS-1:0] reg_sel_c;
    logic [DATA_W-1:0]   regs [NUM_REGS];

    // State, sweep counter and handshake/status flops
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            clr_cnt  <= '0;
            wr_ready <= 1'b0;
            busy     <= 1'b0;
            wr_ack   <= 1'b0;
        end else begin
            state    <= state_nxt;
            clr_cnt  <= clr_cnt_nxt;
            wr_ready <= ready_nxt;
            busy     <= busy_nxt;
            wr_ack   <= ack_nxt;
        end
    end

    // Next state; wr_ready is only ever high in IDLE, so it alone gates acceptance
    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        wr_accept_c = 1'b0;
        clr_step_c  = 1'b0;
        case (state)
            IDLE: begin
                wr_accept_c = wr_valid & wr_ready;
                if (clr_req) begin
                    state_nxt   = CLEAR;
                    clr_cnt_nxt = '0;
                end
            end
            CLEAR: begin
                clr_step_c  = 1'b1;
                clr_cnt_nxt = clr_cnt + ADDR_W'(1);
                if (clr_cnt == ADDR_W'(NUM_REGS - 1)) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        ready_nxt = (state_nxt == IDLE);
        busy_nxt  = (state_nxt == CLEAR);
        ack_nxt   = wr_accept_c | clr_step_c;
    end

`ifdef RF_BYTE_STROBE_EN
    assign be_in_c = wr_be;
`else
    assign be_in_c = '1;
`endif

    // Sweep and host writes never coincide, so one shared write port suffices
    always_comb begin
        cmd_c.addr = clr_step_c ? clr_cnt : wr_addr;
        cmd_c.data = clr_step_c ? CLR_VAL : wr_data;
        cmd_c.be   = clr_step_c ? {BE_W{1'b1}} : be_in_c;
    end

    write_dec4to16 u_dec (
        .en    (wr_accept_c | clr_step_c),
        .addr  (cmd_c.addr),
        .sel_c (reg_sel_c)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (reg_sel_c[i]) regs[i] <= merge_bytes(regs[i], cmd_c.data, cmd_c.be);
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign q[DATA_W*g +: DATA_W] = regs[g];
    end

endmodule
